// File: rtl/ram_burst_if.sv
// ram_burst_if: control/status bundle for the ram_burst data store.
//   master : drives CS_N, OE_N, WE_N, BURST, ADDR, LEN; observes BUSY, DONE
//   slave  : the RAM side (inverse directions)
// The shared DATA bus is a plain inout on the RAM so tri-state resolution
// stays on an ordinary net.
interface ram_burst_if #(
    parameter int ADDR_W = 5
);
    logic              CS_N;
    logic              OE_N;
    logic              WE_N;
    logic              BURST;
    logic [ADDR_W-1:0] ADDR;
    logic [ADDR_W:0]   LEN;
    logic              BUSY;
    logic              DONE;

    modport master (
        output CS_N, OE_N, WE_N, BURST, ADDR, LEN,
        input  BUSY, DONE
    );

    modport slave (
        input  CS_N, OE_N, WE_N, BURST, ADDR, LEN,
        output BUSY, DONE
    );
endinterface

// File: rtl/ram_burst.sv
// ram_burst: single-port synchronous RAM on a shared tri-state data bus.
// Single-word reads/writes from IDLE, plus auto-incrementing burst reads and
// writes whose address counter wraps modulo DEPTH.
//   CLK   : rising-edge clock
//   RST_N : asynchronous active-low reset (memory contents are not cleared)
//   bus   : CS_N/OE_N/WE_N/BURST/ADDR/LEN in, BUSY/DONE out
//   DATA  : bidirectional data bus, driven only while reading
module ram_burst #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST_N,
    ram_burst_if.slave        bus,
    inout  wire  [DATA_W-1:0] DATA
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BWR  = 2'd1,
        BRD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              drv_en;
    logic [ADDR_W-1:0] addr_inc;
    logic              last_beat;

    // Natural ADDR_W-bit overflow gives the modulo-DEPTH wrap.
    assign addr_inc  = addr_q + 1'b1;
    assign last_beat = (rem_q == (ADDR_W+1)'(1));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        dout_d    = dout_q;
        done_d    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = DATA;
        case (state_q)
            IDLE: begin
                if (!bus.CS_N) begin
                    if (bus.BURST) begin
                        // A zero-length burst is dropped entirely.
                        if (bus.LEN != '0) begin
                            addr_d = bus.ADDR;
                            rem_d  = bus.LEN;
                            if (bus.WE_N) begin
                                state_d = BRD;
                                // Prefetch so the first beat is on the bus immediately.
                                dout_d  = mem[bus.ADDR];
                            end else begin
                                state_d = BWR;
                            end
                        end
                    end else if (!bus.WE_N) begin
                        mem_we    = 1'b1;
                        mem_waddr = bus.ADDR;
                    end else begin
                        dout_d = mem[bus.ADDR];
                    end
                end
            end
            BWR: begin
                if (!bus.CS_N) begin
                    mem_we = 1'b1;
                    addr_d = addr_inc;
                    rem_d  = rem_q - 1'b1;
                    if (last_beat) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            BRD: begin
                if (!bus.CS_N) begin
                    addr_d = addr_inc;
                    rem_d  = rem_q - 1'b1;
                    dout_d = mem[addr_inc];
                    if (last_beat) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end

    // Storage deliberately has no reset so contents survive RST_N.
    always_ff @(posedge CLK) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_comb begin
        drv_en = 1'b0;
        case (state_q)
            IDLE:    drv_en = !bus.CS_N && !bus.OE_N && bus.WE_N;
            BRD:     drv_en = !bus.CS_N && !bus.OE_N;
            default: drv_en = 1'b0;
        endcase
    end

    assign DATA     = drv_en ? dout_q : 'z;
    assign bus.BUSY = (state_q != IDLE);
    assign bus.DONE = done_q;
endmodule

// File: tb/tb_ram_burst.sv
// tb_ram_burst: randomized and directed bench for ram_burst against a
// transaction-level memory model (array + modulo addressing).
// The bus is a pulled-up net, so an undriven DATA reads as all ones.
module tb_ram_burst;
    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam logic [DW-1:0] ZV = '1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ram_burst_if #(.ADDR_W(AW)) bif ();
    tri1 [DW-1:0] data_bus;
    logic          tb_drv;
    logic [DW-1:0] tb_dout;
    assign data_bus = tb_drv ? tb_dout : 'z;

    ram_burst #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .bus  (bif),
        .DATA (data_bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [DW-1:0] ref_mem [DEPTH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bif.CS_N  = 1'b1;
        bif.OE_N  = 1'b1;
        bif.WE_N  = 1'b1;
        bif.BURST = 1'b0;
        bif.ADDR  = '0;
        bif.LEN   = '0;
        tb_drv    = 1'b0;
    endtask

    task automatic wr1(input int a, input logic [DW-1:0] d);
        bif.CS_N = 1'b0; bif.OE_N = 1'($urandom_range(0, 1)); bif.WE_N = 1'b0;
        bif.BURST = 1'b0; bif.ADDR = AW'(a); bif.LEN = (AW+1)'($urandom_range(0, 63));
        tb_drv = 1'b1; tb_dout = d;
        @(negedge clk);
        chk("wr1_busy", 32'(bif.BUSY), 0);
        tick();
        ref_mem[a % DEPTH] = d;
        idle_in();
    endtask

    // Address edge, then data is expected in the following cycle.
    task automatic rd1(input int a, input bit zchk);
        bif.CS_N = 1'b0; bif.OE_N = 1'b0; bif.WE_N = 1'b1;
        bif.BURST = 1'b0; bif.ADDR = AW'(a); tb_drv = 1'b0;
        tick();
        @(negedge clk);
        chk("rd1_data", 32'(data_bus), 32'(ref_mem[a % DEPTH]));
        if (zchk) begin
            bif.OE_N = 1'b1;
            #1 chk("rd1_oe_z", 32'(data_bus), 32'(ZV));
            bif.OE_N = 1'b0; bif.CS_N = 1'b1;
            #1 chk("rd1_cs_z", 32'(data_bus), 32'(ZV));
        end
        tick();
        idle_in();
    endtask

    task automatic rand_ignored();
        bif.WE_N  = 1'($urandom_range(0, 1));
        bif.BURST = 1'($urandom_range(0, 1));
        bif.ADDR  = AW'($urandom_range(0, DEPTH-1));
        bif.LEN   = (AW+1)'($urandom_range(0, 63));
    endtask

    task automatic cmd(input int a, input int len, input bit we, input bit exp_done);
        bif.CS_N = 1'b0; bif.OE_N = 1'($urandom_range(0, 1)); bif.WE_N = !we;
        bif.BURST = 1'b1; bif.ADDR = AW'(a); bif.LEN = (AW+1)'(len); tb_drv = 1'b0;
        @(negedge clk);
        chk("cmd_busy", 32'(bif.BUSY), 0);
        if (exp_done) chk("cmd_done", 32'(bif.DONE), 1);
        tick();
    endtask

    task automatic pause(input int n);
        repeat (n) begin
            bif.CS_N = 1'b1; bif.OE_N = 1'b0; tb_drv = 1'b0;
            rand_ignored();
            @(negedge clk);
            chk("pause_busy", 32'(bif.BUSY), 1);
            chk("pause_done", 32'(bif.DONE), 0);
            chk("pause_z", 32'(data_bus), 32'(ZV));
            tick();
        end
    endtask

    // dbase < 0 -> random data; abort_at >= 0 stops before that beat.
    task automatic bwr(input int a, input int len, input int pause_at, input int pause_n,
                       input bit exp_done, input int dbase, input int abort_at);
        logic [DW-1:0] d;
        cmd(a, len, 1'b1, exp_done);
        for (int i = 0; i < len; i++) begin
            if (i == abort_at) break;
            if (i == pause_at) pause(pause_n);
            d = (dbase < 0) ? DW'($urandom) : DW'(dbase + i);
            bif.CS_N = 1'b0; bif.OE_N = 1'($urandom_range(0, 1));
            rand_ignored();
            tb_drv = 1'b1; tb_dout = d;
            @(negedge clk);
            chk("bwr_busy", 32'(bif.BUSY), 1);
            chk("bwr_done", 32'(bif.DONE), 0);
            tick();
            ref_mem[(a + i) % DEPTH] = d;
        end
        idle_in();
    endtask

    task automatic brd(input int a, input int len, input int pause_at, input int pause_n,
                       input bit exp_done);
        cmd(a, len, 1'b0, exp_done);
        for (int i = 0; i < len; i++) begin
            if (i == pause_at) pause(pause_n);
            bif.CS_N = 1'b0; bif.OE_N = 1'b0; tb_drv = 1'b0;
            rand_ignored();
            @(negedge clk);
            chk("brd_busy", 32'(bif.BUSY), 1);
            chk("brd_data", 32'(data_bus), 32'(ref_mem[(a + i) % DEPTH]));
            tick();
        end
        idle_in();
    endtask

    task automatic done_chk();
        idle_in();
        @(negedge clk);
        chk("done_pulse", 32'(bif.DONE), 1);
        chk("done_busy", 32'(bif.BUSY), 0);
        tick();
        @(negedge clk);
        chk("done_clear", 32'(bif.DONE), 0);
        tick();
    endtask

    initial begin
        int a, len, op;
        idle_in();
        tb_dout = '0;
        // Reset state: output register clear, bus shows it in an IDLE read.
        bif.CS_N = 1'b0; bif.OE_N = 1'b0; bif.WE_N = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", 32'(bif.BUSY), 0);
        chk("rst_done", 32'(bif.DONE), 0);
        chk("rst_dout", 32'(data_bus), 0);
        idle_in();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Pattern fill and single reads.
        for (int i = 0; i < DEPTH; i++) wr1(i, DW'(i));
        rd1(12, 1'b1);
        rd1(0, 1'b0);
        rd1(31, 1'b1);

        // Walking ones.
        for (int i = 0; i < 8; i++) wr1(i, DW'(1 << i));
        for (int i = 0; i < 8; i++) rd1(i, 1'b0);

        // Burst write across the top of memory.
        bwr(30, 4, -1, 0, 1'b0, 'hA0, -1);
        done_chk();
        rd1(30, 1'b0); rd1(31, 1'b0); rd1(0, 1'b0); rd1(1, 1'b0);

        // Burst read with a two-cycle pause after beat 2.
        brd(10, 5, 3, 2, 1'b0);
        done_chk();

        // Zero-length burst: ignored, and no write.
        bif.CS_N = 1'b0; bif.OE_N = 1'b1; bif.WE_N = 1'b0; bif.BURST = 1'b1;
        bif.ADDR = AW'(5); bif.LEN = '0; tb_drv = 1'b1; tb_dout = 8'h5A;
        tick();
        idle_in();
        @(negedge clk);
        chk("len0_busy", 32'(bif.BUSY), 0);
        chk("len0_done", 32'(bif.DONE), 0);
        tick();
        rd1(5, 1'b0);

        // Reset after 2 beats of a 6-beat write.
        bwr(20, 6, -1, 0, 1'b0, 'hC0, 2);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bif.BUSY), 0);
        chk("abort_done", 32'(bif.DONE), 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("abort_done2", 32'(bif.DONE), 0);
        tick();
        for (int i = 20; i < 26; i++) rd1(i, 1'b0);

        // Back-to-back: new read burst issued in the DONE cycle.
        brd(3, 3, -1, 0, 1'b0);
        brd(28, 6, -1, 0, 1'b1);
        done_chk();

        // Randomized traffic against the array model.
        for (int k = 0; k < 60; k++) begin
            op  = int'($urandom_range(0, 3));
            a   = int'($urandom_range(0, DEPTH-1));
            len = int'($urandom_range(1, 40));
            case (op)
                0: wr1(a, DW'($urandom));
                1: rd1(a, 1'($urandom_range(0, 1)));
                2: begin
                    bwr(a, len, int'($urandom_range(0, 45)), int'($urandom_range(1, 3)), 1'b0, -1, -1);
                    done_chk();
                end
                default: begin
                    brd(a, len, int'($urandom_range(0, 45)), int'($urandom_range(1, 3)), 1'b0);
                    done_chk();
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
